// File: rtl/reg_move_fsm.sv
// reg_move_fsm: sequences conditional move, move and swap operations
// against an external register file, one register access per cycle.
module reg_move_fsm #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] reg_a,
  input  logic [SEL_W-1:0] reg_b,
  input  logic [SEL_W-1:0] reg_c,
  input  logic [WIDTH-1:0] reg_out_bus,
  output logic [WIDTH-1:0] reg_in_bus,
  output logic [SEL_W-1:0] reg_sel,
  output logic             reg_s,
  output logic             busy,
  output logic             finished,
  output logic             taken
);

  localparam logic [1:0] MODE_CMOV  = 2'b00;
  localparam logic [1:0] MODE_CMOVZ = 2'b01;
  localparam logic [1:0] MODE_MOV   = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_C  = 3'd1,
    RD_A  = 3'd2,
    RD_B  = 3'd3,
    WR_A  = 3'd4,
    WR_B  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         mode_q;
  logic [SEL_W-1:0]   a_q, b_q, c_q;
  logic [WIDTH-1:0]   ta, tb;
  logic               wrote;
  logic               cond;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge r) begin
    if (r) state <= IDLE;
    else   state <= state_nx;
  end

  // Operand latch, read-data temporaries and write tracking.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      mode_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      ta     <= '0;
      tb     <= '0;
      wrote  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        a_q    <= reg_a;
        b_q    <= reg_b;
        c_q    <= reg_c;
        wrote  <= 1'b0;
      end
      if (state == RD_A) ta <= reg_out_bus;
      if (state == RD_B) tb <= reg_out_bus;
      if (state == WR_A) wrote <= 1'b1;
    end
  end

  // Condition test on the full-width value of register c.
  always_comb begin
    cond = 1'b0;
    if (mode_q == MODE_CMOV) cond = (reg_out_bus != '0);
    else                     cond = (reg_out_bus == '0);
  end

  // Next-state decode and per-state register file control.
  always_comb begin
    state_nx   = state;
    reg_sel    = '0;
    reg_s      = 1'b0;
    reg_in_bus = '0;
    busy       = 1'b1;
    finished   = 1'b0;
    taken      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          case (mode)
            MODE_CMOV, MODE_CMOVZ: state_nx = RD_C;
            MODE_MOV:              state_nx = RD_B;
            default:               state_nx = RD_A;
          endcase
        end
      end
      RD_C: begin
        reg_sel  = c_q;
        state_nx = cond ? RD_B : DONE;
      end
      RD_A: begin
        reg_sel  = a_q;
        state_nx = RD_B;
      end
      RD_B: begin
        reg_sel  = b_q;
        state_nx = WR_A;
      end
      WR_A: begin
        reg_sel    = a_q;
        reg_s      = 1'b1;
        reg_in_bus = tb;
        state_nx   = (mode_q == MODE_CMOV || mode_q == MODE_CMOVZ || mode_q == MODE_MOV)
                     ? DONE : WR_B;
      end
      WR_B: begin
        reg_sel    = b_q;
        reg_s      = 1'b1;
        reg_in_bus = ta;
        state_nx   = DONE;
      end
      DONE: begin
        finished = 1'b1;
        taken    = wrote;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/reg_move_fsm.md
REG_MOVE_FSM -- requirements
Module: reg_move_fsm

Interface
REQ-001 Parameter WIDTH, default 32, register data width in bits.
REQ-002 Parameter SEL_W, default 3, register select width; 2**SEL_W registers addressable.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 r  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-006 mode  input  2  operation: 00 CMOV (a<-b if c!=0), 01 CMOVZ (a<-b if c==0), 10 MOV (a<-b), 11 SWAP (a<->b).
REQ-007 reg_a, reg_b, reg_c  input  SEL_W each  operand register selects.
REQ-008 reg_out_bus  input  WIDTH  register file read data for reg_sel, combinational, same cycle.
REQ-009 reg_in_bus  output  WIDTH  write data to register file; all-zero when reg_s=0 (no tristate).
REQ-010 reg_sel  output  SEL_W  register selected for read or write.
REQ-011 reg_s  output  1  1 = register file writes reg_in_bus into reg_sel at next rising edge.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 finished  output  1  one-cycle pulse on operation completion.
REQ-014 taken  output  1  valid with finished: 1 if any register was written.

Function
REQ-015 States: IDLE, RD_C, RD_A, RD_B, WR_A, WR_B, DONE; one state per cycle.
REQ-016 IDLE with start=1: latch mode, reg_a, reg_b, reg_c; next state RD_C for CMOV/CMOVZ, RD_B for MOV, RD_A for SWAP.
REQ-017 start outside IDLE, including DONE, shall be ignored; operands held from latch, input changes mid-operation have no effect.
REQ-018 RD_C: reg_sel=latched c; capture cond = (reg_out_bus!=0) for CMOV, (reg_out_bus==0) for CMOVZ; next RD_B if cond else DONE.
REQ-019 RD_A: reg_sel=latched a; capture ta=reg_out_bus; next RD_B.
REQ-020 RD_B: reg_sel=latched b; capture tb=reg_out_bus; next WR_A.
REQ-021 WR_A: reg_sel=latched a, reg_s=1, reg_in_bus=tb; next WR_B for SWAP, else DONE.
REQ-022 WR_B: reg_sel=latched b, reg_s=1, reg_in_bus=ta; next DONE.
REQ-023 DONE: finished=1, taken=1 if a WR state was visited this operation else 0; reg_sel=0; next IDLE.
REQ-024 IDLE: reg_sel=0, reg_s=0, reg_in_bus=0, busy=0, finished=0, taken=0.
REQ-025 Latency, start edge to finished high: CMOV/CMOVZ taken 4 cycles, not taken 2, MOV 3, SWAP 5; next start accepted the cycle after DONE.
REQ-026 Comparison uses full WIDTH bits; ta/tb are WIDTH bits, no truncation or extension.
REQ-027 SWAP with a==b shall perform both writes and leave the register value unchanged.
REQ-028 CMOV/CMOVZ with c==a or c==b: condition evaluated on the pre-operation value of c.

Reset
REQ-029 r=1 forces IDLE immediately, independent of clk; all outputs take IDLE values of REQ-024 combinationally.
REQ-030 r=1 clears latched operands, ta, tb, cond and taken-tracking to zero.
REQ-031 Reset mid-operation aborts with no further writes; any write whose edge coincided with reset assertion is not guaranteed.
REQ-032 After r deasserts, start is accepted at the first rising edge.

Verification
REQ-033 R1=5,R2=0x1234,R3=7; CMOV a=1,b=2,c=3 -> finished 4 cycles after start, taken=1, R1=0x1234.
REQ-034 R3=0; CMOV a=1,b=2,c=3 -> finished 2 cycles after start, taken=0, R1 unchanged, reg_s never 1.
REQ-035 R3=0; CMOVZ a=1,b=2,c=3 -> R1=R2, taken=1; SWAP R4=0xAAAA5555,R5=0xFFFFFFFF -> after 5 cycles R4=0xFFFFFFFF, R5=0xAAAA5555.
REQ-036 WIDTH=8,SEL_W=4: MOV a=15,b=0,R0=0x80 -> R15=0x80, finished 3 cycles after start.
REQ-037 Assert r during WR_A of SWAP -> outputs zero same cycle, R5 unmodified, next start runs normally.
REQ-038 start held high continuously -> operations back-to-back with one IDLE cycle between; start pulses in DONE produce no extra operation.
